// File: rtl/arb_pkg.sv
// arb_pkg: state encoding and timing defaults shared by the packet arbiter and its tests.
package arb_pkg;
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_GRANT = 3'd1,
        S_XFER  = 3'd2,
        S_DRAIN = 3'd3,
        S_GAP   = 3'd4
    } arb_state_t;
    localparam int IFG_DEFAULT       = 12;
    localparam int START_TMO_DEFAULT = 64;
endpackage

// File: rtl/rr_pick.sv
// rr_pick: one-hot picker scanning req upward from base with wrap, or from index 0 in fixed mode.
module rr_pick #(
    parameter int N  = 4,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] base,
    input  logic          fixed_mode,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] idx
);
    logic [IW-1:0] j;
    logic          found;

    always_comb begin
        grant = '0;
        idx   = '0;
        found = 1'b0;
        j     = '0;
        for (int i = 0; i < N; i++) begin
            j = fixed_mode ? IW'(i) : IW'((int'(base) + i) % N);
            if (!found && req[j]) begin
                found    = 1'b1;
                grant[j] = 1'b1;
                idx      = j;
            end
        end
    end
endmodule

// File: rtl/nch_pkt_arbiter.sv
// nch_pkt_arbiter: grants one of NUM_CH packet buffers at a time and forwards its beats,
// with round-robin/fixed priority, inter-frame gap, length truncation and start timeout.
module nch_pkt_arbiter
    import arb_pkg::*;
#(
    parameter int NUM_CH        = 4,
    parameter int DATA_W        = 8,
    parameter int IFG_CYCLES    = IFG_DEFAULT,
    parameter int MAX_PKT_LEN   = 1518,
    parameter int START_TIMEOUT = START_TMO_DEFAULT
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_CH-1:0]          ch_request,
    input  logic [NUM_CH*DATA_W-1:0]   ch_data,
    input  logic [NUM_CH-1:0]          ch_datavalid,
    output logic [NUM_CH-1:0]          ch_grant,
    input  logic                       prio_mode,
    input  logic                       sender_ready,
    output logic [DATA_W-1:0]          send_data,
    output logic                       send_datav,
    output logic [$clog2(NUM_CH)-1:0]  cur_ch,
    output logic [2:0]                 arb_state,
    output logic                       pkt_trunc,
    output logic                       start_tmo
);
    localparam int IW   = $clog2(NUM_CH);
    localparam int CW   = $clog2(MAX_PKT_LEN + 1);
    localparam int TMAX = START_TIMEOUT > IFG_CYCLES ? START_TIMEOUT : IFG_CYCLES;
    localparam int TW   = $clog2(TMAX + 1);
    localparam logic [CW-1:0] CMAX     = CW'(MAX_PKT_LEN);
    localparam logic [TW-1:0] TMO_LAST = TW'(START_TIMEOUT - 1);
    localparam logic [TW-1:0] GAP_LAST = TW'(IFG_CYCLES - 1);

    arb_state_t        state, state_n;
    logic [NUM_CH-1:0] grant_n, pick_grant;
    logic [IW-1:0]     last, last_n, cur_n, base, pick_idx;
    logic [CW-1:0]     cnt, cnt_n;
    logic [TW-1:0]     tmr, tmr_n;
    logic [DATA_W-1:0] data_n, wdata;
    logic              datav_n, trunc_n, tmo_n, wv;

    assign wv        = ch_datavalid[cur_ch];
    assign wdata     = ch_data[cur_ch*DATA_W +: DATA_W];
    assign base      = (last == IW'(NUM_CH - 1)) ? '0 : last + 1'b1;
    assign arb_state = state;

    rr_pick #(.N(NUM_CH), .IW(IW)) u_pick (
        .req        (ch_request),
        .base       (base),
        .fixed_mode (prio_mode),
        .grant      (pick_grant),
        .idx        (pick_idx)
    );

    always_comb begin
        state_n = state;
        grant_n = ch_grant;
        cur_n   = cur_ch;
        last_n  = last;
        cnt_n   = cnt;
        tmr_n   = tmr;
        data_n  = '0;
        datav_n = 1'b0;
        trunc_n = 1'b0;
        tmo_n   = 1'b0;
        case (state)
            S_IDLE: if (sender_ready && |ch_request) begin
                state_n = S_GRANT;
                grant_n = pick_grant;
                cur_n   = pick_idx;
                last_n  = pick_idx;
                cnt_n   = '0;
                tmr_n   = '0;
            end
            S_GRANT: if (wv) begin
                state_n = S_XFER;
                datav_n = 1'b1;
                data_n  = wdata;
                cnt_n   = CW'(1);
            end else if (tmr == TMO_LAST) begin
                state_n = S_GAP;
                grant_n = '0;
                tmo_n   = 1'b1;
                tmr_n   = '0;
            end else begin
                tmr_n = tmr + 1'b1;
            end
            S_XFER: if (!wv) begin
                state_n = S_GAP;
                grant_n = '0;
                tmr_n   = '0;
            end else if (cnt == CMAX) begin
                // Beat beyond the length limit is dropped; the rest of the packet drains unforwarded.
                state_n = S_DRAIN;
                trunc_n = 1'b1;
            end else begin
                datav_n = 1'b1;
                data_n  = wdata;
                cnt_n   = cnt + 1'b1;
            end
            S_DRAIN: if (!wv) begin
                state_n = S_GAP;
                grant_n = '0;
                tmr_n   = '0;
            end
            S_GAP: if (tmr == GAP_LAST) state_n = S_IDLE;
                   else tmr_n = tmr + 1'b1;
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            ch_grant   <= '0;
            cur_ch     <= '0;
            last       <= IW'(NUM_CH - 1);
            cnt        <= '0;
            tmr        <= '0;
            send_data  <= '0;
            send_datav <= 1'b0;
            pkt_trunc  <= 1'b0;
            start_tmo  <= 1'b0;
        end else begin
            state      <= state_n;
            ch_grant   <= grant_n;
            cur_ch     <= cur_n;
            last       <= last_n;
            cnt        <= cnt_n;
            tmr        <= tmr_n;
            send_data  <= data_n;
            send_datav <= datav_n;
            pkt_trunc  <= trunc_n;
            start_tmo  <= tmo_n;
        end
    end
endmodule

// File: doc/nch_pkt_arbiter.md
NCH_PKT_ARBITER -- requirements
Module: nch_pkt_arbiter

Interface
REQ-001 SHALL have parameter NUM_CH, default 4, number of input channels (legal 2..16).
REQ-002 SHALL have parameter DATA_W, default 8, stream data width.
REQ-003 SHALL have parameter IFG_CYCLES, default 12, idle cycles forced between packets (legal 1..255).
REQ-004 SHALL have parameter MAX_PKT_LEN, default 1518, max beats forwarded per packet.
REQ-005 SHALL have parameter START_TIMEOUT, default 64, cycles from grant to first valid before grant is revoked.
REQ-006 clk  in  1  single clock; all logic on rising edge.
REQ-007 rst  in  1  synchronous, active-high reset.
REQ-008 ch_request  in  NUM_CH  per-channel "packet buffered, ready to send".
REQ-009 ch_data  in  NUM_CH*DATA_W  channel i data at bits [i*DATA_W +: DATA_W].
REQ-010 ch_datavalid  in  NUM_CH  per-channel data valid.
REQ-011 ch_grant  out  NUM_CH  one-hot grant to the selected channel buffer.
REQ-012 prio_mode  in  1  0 = round-robin, 1 = fixed priority (ch0 highest); sampled only in IDLE.
REQ-013 sender_ready  in  1  downstream sender idle, may accept a new packet.
REQ-014 send_data  out  DATA_W  forwarded data.
REQ-015 send_datav  out  1  forwarded data valid.
REQ-016 cur_ch  out  $clog2(NUM_CH)  index of the granted/last granted channel.
REQ-017 arb_state  out  3  current state encoding (debug).
REQ-018 pkt_trunc  out  1  one-cycle pulse when a packet is truncated at MAX_PKT_LEN.
REQ-019 start_tmo  out  1  one-cycle pulse when START_TIMEOUT expires.

Function
REQ-020 SHALL implement states IDLE(0), GRANT(1), XFER(2), DRAIN(3), GAP(4).
REQ-021 IDLE: when sender_ready=1 and any ch_request=1, SHALL select a winner, assert its ch_grant next cycle, and go to GRANT.
REQ-022 Round-robin selection SHALL scan from (last winner+1) mod NUM_CH upward with wrap; fixed priority SHALL pick the lowest requesting index.
REQ-023 GRANT: first ch_datavalid=1 of the winner SHALL move to XFER; other channels' request/valid SHALL be ignored.
REQ-024 GRANT: after START_TIMEOUT cycles without valid SHALL pulse start_tmo, drop the grant, and go to GAP; the pointer still advances.
REQ-025 XFER: send_data/send_datav SHALL equal the winner's data/valid delayed by exactly one clk (registered).
REQ-026 XFER: the beat counter SHALL count forwarded beats; the end of packet is the first cycle with winner valid=0, which goes to GAP.
REQ-027 XFER: if a valid beat arrives when the counter equals MAX_PKT_LEN, SHALL drop it, pulse pkt_trunc, and go to DRAIN.
REQ-028 DRAIN: send_datav SHALL be 0; the grant stays asserted until winner valid=0, then goes to GAP.
REQ-029 ch_grant SHALL be asserted in GRANT, XFER and DRAIN only, and deasserted on the cycle GAP is entered.
REQ-030 GAP: SHALL hold send_datav=0 for exactly IFG_CYCLES cycles, then return to IDLE.
REQ-031 The counter width SHALL be $clog2(MAX_PKT_LEN+1); the counter saturates and never wraps.
REQ-032 Deassertion of ch_request after grant SHALL have no effect; sender_ready SHALL be examined only in IDLE.

Reset
REQ-033 rst=1 SHALL, on the next edge and from any state, force IDLE, ch_grant=0, send_data=0, send_datav=0, pkt_trunc=0, start_tmo=0, cur_ch=0, counters=0.
REQ-034 After reset the round-robin pointer SHALL be NUM_CH-1, so ch0 wins the first round-robin scan; an in-flight packet is abandoned without truncation pulse.

Structure
REQ-035 The state enum, state encodings and the IFG/timeout default constants SHALL live in shared package arb_pkg.
REQ-036 The rotating-base one-hot picker SHALL be sub-module rr_pick (inputs req, base, fixed_mode; output one-hot grant plus index).

Verification
REQ-037 NUM_CH=4 round-robin; ch0..ch3 all request, 10-beat packets each -> grant order 0,1,2,3,0, with ≥12 idle cycles between send_datav bursts.
REQ-038 prio_mode=1; ch2 and ch3 request repeatedly -> ch2 always wins and ch3 starves while ch2 is requesting.
REQ-039 MAX_PKT_LEN=16; ch1 sends 20 beats -> exactly 16 send_datav beats, pkt_trunc pulses once, and grant holds until ch1 valid falls.
REQ-040 ch0 requests but never asserts valid -> start_tmo pulses 64 cycles after grant, grant drops, and the next request goes to ch1.
REQ-041 rst asserted mid-XFER of beat 5 -> all outputs are 0 next cycle; after release, ch0 wins first.
REQ-042 sender_ready=0 with requests pending -> no grant; grant issues the cycle after sender_ready rises.
